vec_exec_unit_pipe: RTL and testbench

//  Handshaked, parametrised vector execution unit: per-element add, sub, mul-low, mul-high at SEW 8/16/32.

---
 rtl/vec_exec_pkg.sv | 43 ++++
 rtl/vec_exec_unit_pipe_alu.sv | 53 +++++
 rtl/vec_exec_unit_pipe.sv | 134 +++++++++++++
 tb/tb_vec_exec_unit_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_exec_pkg.sv
// Shared types and decode helpers for the vector execution unit.
package vec_exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b011,
        OP_MULH = 3'b100
    } exec_op_e;

    typedef enum logic [1:0] {
        SEW8    = 2'b00,
        SEW16   = 2'b01,
        SEW32   = 2'b10,
        SEW_BAD = 2'b11
    } sew_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    // One-hot SEW select from decode; anything other than the three
    // supported encodings maps to SEW_BAD.
    function automatic sew_e decode_sew(input logic [5:0] onehot);
        case (onehot)
            6'b001000: return SEW8;
            6'b010000: return SEW16;
            6'b100000: return SEW32;
            default:   return SEW_BAD;
        endcase
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_MULH);
    endfunction

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/vec_exec_unit_pipe_alu.sv
// Combinational SEW-partitioned lane ALU: add, sub, mul-low, mul-high.
module vec_lane_alu #(
    parameter int VLEN = 512
) (
    input  logic [VLEN-1:0] i_a,
    input  logic [VLEN-1:0] i_b,
    input  logic [1:0]      i_sew,
    input  logic [2:0]      i_op,
    input  logic            i_signed,
    output logic [VLEN-1:0] o_result
);
    import vec_exec_pkg::*;

    // One full-width result per element size; index 0/1/2 = SEW 8/16/32.
    logic [2:0][VLEN-1:0] w_res;

    for (genvar k = 0; k < 3; k++) begin : g_sew
        localparam int W = 8 << k;
        for (genvar i = 0; i < VLEN / W; i++) begin : g_lane
            logic [W-1:0]   w_a;
            logic [W-1:0]   w_b;
            logic [2*W-1:0] w_xa;
            logic [2*W-1:0] w_xb;
            logic [2*W-1:0] w_prod;

            assign w_a = i_a[i*W +: W];
            assign w_b = i_b[i*W +: W];
            // Extending to 2*SEW first makes one multiplier serve both
            // signednesses; the low half is identical either way.
            assign w_xa   = i_signed ? {{W{w_a[W-1]}}, w_a} : {{W{1'b0}}, w_a};
            assign w_xb   = i_signed ? {{W{w_b[W-1]}}, w_b} : {{W{1'b0}}, w_b};
            assign w_prod = w_xa * w_xb;

            assign w_res[k][i*W +: W] =
                (i_op == OP_ADD)  ? w_a + w_b         :
                (i_op == OP_SUB)  ? w_a - w_b         :
                (i_op == OP_MUL)  ? w_prod[W-1:0]     :
                (i_op == OP_MULH) ? w_prod[2*W-1:W]   : '0;
        end
    end

    // Select the partitioning that matches the captured element size.
    always_comb begin
        o_result = '0;
        case (i_sew)
            SEW8:    o_result = w_res[0];
            SEW16:   o_result = w_res[1];
            SEW32:   o_result = w_res[2];
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/vec_exec_unit_pipe.sv
// Handshaked vector execution unit: captures one op, waits a fixed
// latency (longer for multiplies), then holds the result until taken.
module vec_exec_unit_pipe #(
    parameter int VLEN    = 512,
    parameter int MUL_LAT = 4,
    parameter int ADD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [VLEN-1:0] data_1,
    input  logic [VLEN-1:0] data_2,
    input  logic [5:0]      sew_eew_mux_out,
    input  logic [2:0]      execution_op,
    input  logic            signed_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [VLEN-1:0] result,
    output logic [1:0]      sew,
    output logic            illegal,
    output logic            busy
);
    import vec_exec_pkg::*;

    localparam int MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] ADD_CNT = CNT_W'(ADD_LAT - 1);

    state_e            r_state;
    state_e            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [VLEN-1:0]   r_a;
    logic [VLEN-1:0]   r_b;
    logic [1:0]        r_sew_cap;
    logic [2:0]        r_op;
    logic              r_sgn;
    logic              r_bad_cap;
    logic [VLEN-1:0]   r_result;
    logic [1:0]        r_sew_out;
    logic              r_illegal;

    sew_e              w_in_sew;
    logic              w_in_bad;
    logic              w_in_mul;
    logic              w_accept;
    logic              w_finish;
    logic [VLEN-1:0]   w_alu_res;

    assign w_in_sew = decode_sew(sew_eew_mux_out);
    assign w_in_bad = (w_in_sew == SEW_BAD) || !op_is_legal(execution_op);
    // Illegal ops always take the short path, even if the opcode is a multiply.
    assign w_in_mul = op_is_mul(execution_op) && !w_in_bad;
    assign w_accept = in_valid && (r_state == IDLE);
    assign w_finish = (r_state == EXEC) && (r_cnt == '0);

    vec_lane_alu #(.VLEN(VLEN)) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sew    (r_sew_cap),
        .i_op     (r_op),
        .i_signed (r_sgn),
        .o_result (w_alu_res)
    );

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_next = EXEC;
            end
            EXEC: begin
                if (r_cnt == '0) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt <= w_in_mul ? MUL_CNT : ADD_CNT;
            end else if ((r_state == EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Operand capture; only meaningful once a request is accepted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a       <= data_1;
            r_b       <= data_2;
            r_sew_cap <= w_in_sew;
            r_op      <= execution_op;
            r_sgn     <= signed_mode;
            r_bad_cap <= w_in_bad;
        end
    end

    // Result register; loaded at the end of EXEC and held through DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result  <= '0;
            r_sew_out <= SEW_BAD;
            r_illegal <= 1'b0;
        end else if (w_finish) begin
            r_result  <= r_bad_cap ? '0 : w_alu_res;
            r_sew_out <= r_sew_cap;
            r_illegal <= r_bad_cap;
        end
    end

    assign result  = r_result;
    assign sew     = r_sew_out;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_vec_exec_unit_pipe.sv
// Scoreboard bench for vec_exec_unit_pipe: directed vectors push expected
// results; a monitor pops and compares on each output handshake.
module tb_vec_exec_unit_pipe;

    localparam int VLEN    = 512;
    localparam int MUL_LAT = 4;
    localparam int ADD_LAT = 1;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [VLEN-1:0] data_1;
    logic [VLEN-1:0] data_2;
    logic [5:0]      sew_oh;
    logic [2:0]      op;
    logic            sgn;
    logic            out_valid;
    logic            out_ready;
    logic [VLEN-1:0] result;
    logic [1:0]      sew;
    logic            illegal;
    logic            busy;

    typedef struct {
        logic [VLEN-1:0] res;
        logic [1:0]      sew;
        logic            ill;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    vec_exec_unit_pipe #(.VLEN(VLEN), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .data_1          (data_1),
        .data_2          (data_2),
        .sew_eew_mux_out (sew_oh),
        .execution_op    (op),
        .signed_mode     (sgn),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .result          (result),
        .sew             (sew),
        .illegal         (illegal),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] rep8(input logic [7:0] x);
        return {(VLEN/8){x}};
    endfunction
    function automatic logic [VLEN-1:0] rep16(input logic [15:0] x);
        return {(VLEN/16){x}};
    endfunction
    function automatic logic [VLEN-1:0] rep32(input logic [31:0] x);
        return {(VLEN/32){x}};
    endfunction

    // Monitor: every accepted output beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got out_valid=1 want no pending op");
            end else begin
                mon_e = sb_q.pop_front();
                chk("mon_result", result, mon_e.res);
                chki("mon_sew", int'(sew), int'(mon_e.sew));
                chki("mon_illegal", int'(illegal), int'(mon_e.ill));
            end
        end
    end

    // Issue one op from an idle point (#1 after a rising edge), check its
    // latency, optionally stall the output for 'hold' cycles, then release.
    task automatic run_op(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                          input logic [5:0] sh, input logic [2:0] o, input logic s,
                          input logic [VLEN-1:0] er, input logic [1:0] es, input logic ei,
                          input int elat, input int hold);
        int lat;
        exp_t e;
        out_ready = (hold == 0);
        data_1    = a;
        data_2    = b;
        sew_oh    = sh;
        op        = o;
        sgn       = s;
        in_valid  = 1'b1;
        chki("in_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.res = er;
        e.sew = es;
        e.ill = ei;
        sb_q.push_back(e);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        chki("latency", lat, elat);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                in_valid = 1'b1;
                data_1   = rep8(8'hAA);
                op       = 3'b000;
                sew_oh   = 6'b001000;
                @(posedge clk);
                #1;
                chki("hold_valid", int'(out_valid), 1);
                chk("hold_result", result, er);
                chki("hold_in_ready", int'(in_ready), 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chki("release_in_ready", int'(in_ready), 1);
        chki("release_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_1    = '0;
        data_2    = '0;
        sew_oh    = 6'b001000;
        op        = 3'b000;
        sgn       = 1'b0;
        out_ready = 1'b0;
        #12;
        chki("rst_in_ready", int'(in_ready), 1);
        chki("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", result, '0);
        chki("rst_sew", int'(sew), 3);
        chki("rst_illegal", int'(illegal), 0);
        chki("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(rep8(8'hFF), rep8(8'h01), 6'b001000, 3'b000, 1'b0, rep8(8'h00), 2'b00, 1'b0, ADD_LAT, 0);
        run_op(rep16(16'h00FF), rep16(16'h0001), 6'b010000, 3'b000, 1'b0, rep16(16'h0100), 2'b01, 1'b0, ADD_LAT, 0);
        run_op(rep16(16'h0000), rep16(16'h0001), 6'b010000, 3'b001, 1'b0, rep16(16'hFFFF), 2'b01, 1'b0, ADD_LAT, 0);
        run_op(rep32(32'h00010000), rep32(32'h00010000), 6'b100000, 3'b011, 1'b0, rep32(32'h0), 2'b10, 1'b0, MUL_LAT, 0);
        run_op(rep32(32'h00010000), rep32(32'h00010000), 6'b100000, 3'b100, 1'b0, rep32(32'h1), 2'b10, 1'b0, MUL_LAT, 0);
        run_op(rep8(8'h80), rep8(8'h02), 6'b001000, 3'b100, 1'b1, rep8(8'hFF), 2'b00, 1'b0, MUL_LAT, 0);
        run_op(rep8(8'h80), rep8(8'h02), 6'b001000, 3'b100, 1'b0, rep8(8'h01), 2'b00, 1'b0, MUL_LAT, 0);
        run_op(rep8(8'h05), rep8(8'h07), 6'b001000, 3'b001, 1'b0, rep8(8'hFE), 2'b00, 1'b0, ADD_LAT, 5);
        run_op(rep8(8'hFF), rep8(8'h01), 6'b000001, 3'b000, 1'b0, '0, 2'b11, 1'b1, ADD_LAT, 0);
        run_op(rep8(8'hFF), rep8(8'h01), 6'b001000, 3'b111, 1'b0, '0, 2'b00, 1'b1, ADD_LAT, 0);
        run_op(rep8(8'h03), rep8(8'h05), 6'b011000, 3'b011, 1'b0, '0, 2'b11, 1'b1, ADD_LAT, 0);
        run_op(rep16(16'h1234), rep16(16'h0010), 6'b010000, 3'b011, 1'b0, rep16(16'h2340), 2'b01, 1'b0, MUL_LAT, 0);

        // Reset in the second EXEC cycle of a multiply.
        data_1    = rep16(16'h1234);
        data_2    = rep16(16'h0010);
        sew_oh    = 6'b010000;
        op        = 3'b011;
        sgn       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chki("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chki("mrst_in_ready", int'(in_ready), 1);
        chki("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_result", result, '0);
        chki("mrst_sew", int'(sew), 3);
        chki("mrst_illegal", int'(illegal), 0);
        chki("mrst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < MUL_LAT + 4; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chki("post_reset_no_valid", seen, 0);
        chki("scoreboard_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
